// File: rtl/frv_interrupt_ctrl_if.sv
// frv_interrupt_ctrl_if
//   Core MMIO bus as seen by the interrupt controller register window.
//   en     access strobe (one cycle per access)
//   wen    1 = write, 0 = read
//   addr   byte address
//   wdata  write data
//   rdata  read data, registered, zero on non-hit cycles
//   error  access error, registered, zero on non-hit cycles
interface frv_interrupt_ctrl_if;
  logic        en;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport master (output en, wen, addr, wdata, input rdata, error);
  modport slave  (input en, wen, addr, wdata, output rdata, error);
endinterface

// File: rtl/frv_interrupt_ctrl.sv
// frv_interrupt_ctrl
//   Merges NUM_EXT external lines (synchronised, per-line enable and
//   edge/level mode) with the timer and software sources, and drives a
//   stable req/ack trap handshake towards the WB stage.
// Ports
//   g_clk, g_resetn         clock, asynchronous active-low reset
//   ext_irq                 raw external lines (asynchronous)
//   ti_pending, sw_pending  timer / software sources
//   mstatus_mie, mie_*      global and per-source enables
//   mip_meip/mtip/msip      pending status towards the CSR file
//   int_trap_req/cause/ack  trap handshake with the WB stage
//   mmio                    register window (PEND, ENABLE, MODE, CLAIM)
//
// Trap FSM
//   state   | meaning
//   IDLE    | no request; arbitrate sources each cycle
//   REQ     | int_trap_req high, int_trap_cause frozen
//   ACKD    | trap taken; one dead cycle before re-arbitration
module frv_interrupt_ctrl #(
  parameter int          NUM_EXT        = 8,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_2000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_FFE0
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               ti_pending,
  input  logic               sw_pending,
  input  logic               mstatus_mie,
  input  logic               mie_meie,
  input  logic               mie_mtie,
  input  logic               mie_msie,
  output logic               mip_meip,
  output logic               mip_mtip,
  output logic               mip_msip,
  output logic               int_trap_req,
  output logic [5:0]         int_trap_cause,
  input  logic               int_trap_ack,
  frv_interrupt_ctrl_if.slave mmio
);

  localparam logic [5:0] CAUSE_MEI = 6'd11;
  localparam logic [5:0] CAUSE_MSI = 6'd3;
  localparam logic [5:0] CAUSE_MTI = 6'd7;

  localparam logic [1:0] SEL_PEND   = 2'd0;
  localparam logic [1:0] SEL_ENABLE = 2'd1;
  localparam logic [1:0] SEL_MODE   = 2'd2;
  localparam logic [1:0] SEL_CLAIM  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKD} state_t;

  // ---------------------------------------------------------------- sync
  logic [NUM_EXT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_EXT-1:0] sync_s;
  logic [NUM_EXT-1:0] sync_prev;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sync_prev <= sync_s;
    end
  end

  // ---------------------------------------------------------------- mmio decode
  logic [NUM_EXT-1:0] pend_q, enable_q, mode_q;
  logic [NUM_EXT-1:0] active, claim_sel, clr, pend_nxt, rise, wdata_ext;
  logic [31:0]        offset, claim_val, rdata_nxt, rdata_q;
  logic [1:0]         reg_sel;
  logic               hit, bad, acc_ok, wr, rd, error_q;
  logic               unused_wdata;

  assign wdata_ext    = mmio.wdata[NUM_EXT-1:0];
  assign unused_wdata = ^mmio.wdata[31:NUM_EXT];

  assign hit     = mmio.en && ((mmio.addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
  assign offset  = mmio.addr & ~MMIO_BASE_MASK;
  assign reg_sel = offset[3:2];
  assign bad     = (offset >= 32'h10) || (mmio.addr[1:0] != 2'b00) ||
                   (mmio.wen && (reg_sel == SEL_CLAIM));
  assign acc_ok  = hit && !bad;
  assign wr      = acc_ok && mmio.wen;
  assign rd      = acc_ok && !mmio.wen;

  assign active  = pend_q & enable_q;
  assign rise    = sync_s & ~sync_prev;

  // Descending scan so the lowest active index is the last one written.
  always_comb begin
    claim_sel = '0;
    claim_val = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_sel    = '0;
        claim_sel[i] = 1'b1;
        claim_val    = 32'(i + 1);
      end
    end
  end

  // Clears only touch edge-mode lines; a same-cycle rising edge wins.
  always_comb begin
    clr = '0;
    if (wr && (reg_sel == SEL_PEND)) clr = wdata_ext;
    if (rd && (reg_sel == SEL_CLAIM)) clr = clr | claim_sel;
    pend_nxt = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & sync_s);
  end

  always_comb begin
    rdata_nxt = '0;
    if (rd) begin
      case (reg_sel)
        SEL_PEND:   rdata_nxt = 32'(pend_q);
        SEL_ENABLE: rdata_nxt = 32'(enable_q);
        SEL_MODE:   rdata_nxt = 32'(mode_q);
        default:    rdata_nxt = claim_val;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      pend_q  <= pend_nxt;
      rdata_q <= rdata_nxt;
      error_q <= hit && bad;
      if (wr && (reg_sel == SEL_ENABLE)) enable_q <= wdata_ext;
      if (wr && (reg_sel == SEL_MODE))   mode_q   <= wdata_ext;
    end
  end

  assign mmio.rdata = rdata_q;
  assign mmio.error = error_q;

  // ---------------------------------------------------------------- sources
  logic mtip_q, msip_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      mtip_q <= ti_pending;
      msip_q <= sw_pending;
    end
  end

  assign mip_meip = |active;
  assign mip_mtip = mtip_q;
  assign mip_msip = msip_q;

  logic mei_c, msi_c, mti_c, cand, live;

  assign mei_c = mstatus_mie & mie_meie & mip_meip;
  assign msi_c = mstatus_mie & mie_msie & mip_msip;
  assign mti_c = mstatus_mie & mie_mtie & mip_mtip;
  assign cand  = mei_c | msi_c | mti_c;

  // ---------------------------------------------------------------- trap FSM
  state_t     state_q, state_nxt;
  logic [5:0] cause_q, cause_nxt;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cause_nxt = cause_q;
    live      = 1'b0;
    case (cause_q)
      CAUSE_MEI: live = mei_c;
      CAUSE_MSI: live = msi_c;
      default:   live = mti_c;
    endcase
    case (state_q)
      ST_IDLE: begin
        if (cand) begin
          state_nxt = ST_REQ;
          if (mei_c)      cause_nxt = CAUSE_MEI;
          else if (msi_c) cause_nxt = CAUSE_MSI;
          else            cause_nxt = CAUSE_MTI;
        end
      end
      ST_REQ: begin
        if (int_trap_ack) state_nxt = ST_ACKD;
        else if (!live)   state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign int_trap_req   = (state_q == ST_REQ);
  assign int_trap_cause = cause_q;

endmodule
